// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, frame constants and checksum helper for the UART command controller.
// Pure declarations: no logic, no latency, no flow control.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } cmd_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Frame checksum: 8-bit wrapping sum of address and data.
  function automatic logic [7:0] chk8(input logic [7:0] addr, input logic [7:0] data);
    return addr + data;
  endfunction

endpackage

// File: rtl/uart_byte_hs.sv
// Receiver handshake: accepts a byte when rx_rdy=1 and rdy_clr=0, answering with a one-cycle rdy_clr.
// byte_vld is combinational on the accept edge; the rdy_clr guard blocks re-accepting the same byte.
module uart_byte_hs (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rdy_clr,
  output logic       byte_vld,
  output logic [7:0] byte_dat
);

  logic rdy_clr_q, rdy_clr_d;

  always_comb begin
    byte_vld  = rx_rdy & ~rdy_clr_q;
    byte_dat  = rx_data;
    rdy_clr_d = byte_vld;
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      rdy_clr_q <= 1'b0;
    end else begin
      rdy_clr_q <= rdy_clr_d;
    end
  end

  assign rdy_clr = rdy_clr_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles SYNC/ADDR/DATA/CHK frames from the UART receiver and issues a register-write strobe one cycle after a good CHK byte.
// Optional inter-byte timeout compiled in with UART_CMD_TIMEOUT_EN; without it a frame may stall indefinitely.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned ERR_CNT_W      = 8
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rx_rdy,
  input  logic [7:0]           rx_data,
  output logic                 rdy_clr,
  output logic                 wr_en,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 chk_err,
  output logic                 timeout_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  cmd_state_e           state_q, state_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 wr_en_q, wr_en_d;
  logic                 chk_err_q, chk_err_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 byte_vld;
  logic [7:0]           byte_dat;
  logic                 to_expire;

  uart_byte_hs u_byte_hs (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rdy_clr  (rdy_clr),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned     TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_expire = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q + 1'b1;
    if (byte_vld || (state_q == ST_IDLE) || to_expire) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign to_expire          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_cnt_d     = err_cnt_q;

    // An accepted byte outranks a timeout expiring on the same edge.
    if (byte_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_dat == SYNC_BYTE) begin
            state_d = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_d  = byte_dat;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          data_d  = byte_dat;
          state_d = ST_CHK;
        end
        ST_CHK: begin
          state_d = ST_IDLE;
          if (byte_dat == chk8(addr_q, data_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = data_q;
          end else begin
            chk_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_expire) begin
      state_d       = ST_IDLE;
      timeout_err_d = 1'b1;
    end

    if ((chk_err_d || timeout_err_d) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = timeout_err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: receiver emulation, queue-based frame model compared every cycle, plus directed literal checks.
module tb_uart_cmd_ctrl;

  localparam int TO   = 100;
  localparam int EMAX = 255;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rx_rdy  = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rdy_clr, wr_en, chk_err, timeout_err, busy;
  logic [7:0] wr_addr, wr_data, err_cnt;

  int tests = 0;
  int fails = 0;

  always #10 clk_50m = ~clk_50m;

  uart_cmd_ctrl #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .ERR_CNT_W      (8)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .rdy_clr     (rdy_clr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .chk_err     (chk_err),
    .timeout_err (timeout_err),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  // Reference model: bytes of the frame in progress are kept in a queue.
  logic       m_clr = 1'b0, m_wr = 1'b0, m_chk = 1'b0, m_to = 1'b0;
  logic [7:0] m_wa = 8'h00, m_wd = 8'h00;
  int         m_err = 0;
  int         m_idle = 0;
  logic [7:0] fb[$];
  logic       armed = 1'b0;
  int         cyc = 0;

  always @(posedge clk_50m) begin : model
    logic acc;
    cyc++;
    if (!rst_n) begin
      m_clr = 1'b0; m_wr = 1'b0; m_chk = 1'b0; m_to = 1'b0;
      m_wa = 8'h00; m_wd = 8'h00; m_err = 0; m_idle = 0;
      fb.delete();
      armed = 1'b1;
    end else begin
      acc   = rx_rdy && !m_clr;
      m_wr  = 1'b0; m_chk = 1'b0; m_to = 1'b0;
      if (acc) begin
        m_idle = 0;
        if (fb.size() != 0 || rx_data == 8'hA5) fb.push_back(rx_data);
        if (fb.size() == 4) begin
          if (fb[3] == 8'(fb[1] + fb[2])) begin
            m_wr = 1'b1; m_wa = fb[1]; m_wd = fb[2];
          end else begin
            m_chk = 1'b1;
            if (m_err < EMAX) m_err++;
          end
          fb.delete();
        end
      end
`ifdef UART_CMD_TIMEOUT_EN
      else if (fb.size() != 0) begin
        if (m_idle == TO - 1) begin
          m_to = 1'b1;
          if (m_err < EMAX) m_err++;
          fb.delete();
          m_idle = 0;
        end else begin
          m_idle++;
        end
      end
`endif
      m_clr = acc;
    end
  end

  // Per-cycle compare plus DUT-side event monitor for the directed checks.
  int         n_wr = 0, n_chk = 0, n_to = 0, n_clr = 0;
  logic [7:0] o_wa = 8'h00, o_wd = 8'h00;
  int         acc_edge = 0, wr_edge = 0, to_edge = 0;

  always @(negedge clk_50m) begin
    if (armed) begin
      tests++;
      if ({rdy_clr, wr_en, chk_err, timeout_err, busy} !== {m_clr, m_wr, m_chk, m_to, (fb.size() != 0)} ||
          err_cnt !== 8'(m_err) || wr_addr !== m_wa || wr_data !== m_wd) begin
        fails++;
        $display("FAIL cycle %0d: got clr/wr/chk/to/busy=%b%b%b%b%b err=%0d wa=%h wd=%h, want %b%b%b%b%b err=%0d wa=%h wd=%h",
                 cyc, rdy_clr, wr_en, chk_err, timeout_err, busy, err_cnt, wr_addr, wr_data,
                 m_clr, m_wr, m_chk, m_to, (fb.size() != 0), m_err, m_wa, m_wd);
      end
    end
    if (rdy_clr === 1'b1) begin n_clr++; acc_edge = cyc; end
    if (wr_en === 1'b1) begin n_wr++; o_wa = wr_addr; o_wd = wr_data; wr_edge = cyc + 1; end
    if (chk_err === 1'b1) n_chk++;
    if (timeout_err === 1'b1) begin n_to++; to_edge = cyc; end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  logic [7:0] txq[$];

  // Receiver emulation: rdy clears on an edge that samples rdy_clr=1 unless a new byte sets it on that edge.
  task automatic send(input int max_gap);
    int   i;
    int   gap;
    int   budget;
    logic clr_seen;
    i      = 0;
    gap    = $urandom_range(0, max_gap);
    budget = 20 * txq.size() + 50;
    while ((i < txq.size() || rx_rdy) && budget > 0) begin
      @(negedge clk_50m);
      clr_seen = rdy_clr;
      @(posedge clk_50m);
      #1;
      budget--;
      if (i < txq.size() && gap == 0 && (!rx_rdy || clr_seen)) begin
        rx_rdy  = 1'b1;
        rx_data = txq[i];
        i++;
        gap = $urandom_range(0, max_gap);
      end else begin
        if (clr_seen) rx_rdy = 1'b0;
        if (gap > 0) gap--;
      end
    end
    check("send_done", int'(budget > 0), 1);
    rx_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk_50m);
    #1;
    rst_n  = 1'b0;
    rx_rdy = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int         w0, c0, k0, t0, a5_edge, exp_wr, exp_chk, kind, nj;
    logic [7:0] a, d, j;

    repeat (3) @(posedge clk_50m);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_strobes", int'({rdy_clr, wr_en, chk_err, timeout_err}), 0);
    check("rst_wr_bus", int'({wr_addr, wr_data}), 0);
    rst_n = 1'b1;

    // Good frame
    w0 = n_wr;
    txq = '{8'hA5, 8'h10, 8'h22, 8'h32};
    send(2); idle(3);
    check("good_wr_count", n_wr - w0, 1);
    check("good_wr_addr", int'(o_wa), 'h10);
    check("good_wr_data", int'(o_wd), 'h22);
    check("good_latency", wr_edge - acc_edge, 1);
    check("good_err_cnt", int'(err_cnt), 0);

    // Bad checksum
    w0 = n_wr; c0 = n_chk;
    txq = '{8'hA5, 8'h10, 8'h22, 8'h33};
    send(2); idle(3);
    check("bad_no_wr", n_wr - w0, 0);
    check("bad_chk_pulses", n_chk - c0, 1);
    check("bad_err_cnt", int'(err_cnt), 1);
    check("bad_busy", int'(busy), 0);

    // Leading junk plus wrapping checksum
    w0 = n_wr; c0 = n_chk;
    txq = '{8'h00, 8'hFF, 8'hA5, 8'hF0, 8'h20, 8'h10};
    send(1); idle(3);
    check("junk_wr_count", n_wr - w0, 1);
    check("junk_wr_addr", int'(o_wa), 'hF0);
    check("junk_wr_data", int'(o_wd), 'h20);
    check("junk_no_chk", n_chk - c0, 0);

    // Back-to-back bytes: rx_rdy stays high across bytes
    w0 = n_wr; k0 = n_clr;
    txq = '{8'hA5, 8'h33, 8'h44, 8'h77};
    send(0); idle(3);
    check("b2b_accepts", n_clr - k0, 4);
    check("b2b_wr_count", n_wr - w0, 1);
    check("b2b_wr_data", int'(o_wd), 'h44);

    // Reset mid-frame
    txq = '{8'hA5, 8'h10};
    send(1);
    check("mid_busy", int'(busy), 1);
    do_reset();
    check("mid_rst_busy", int'(busy), 0);
    w0 = n_wr;
    txq = '{8'hA5, 8'h01, 8'h02, 8'h03};
    send(1); idle(3);
    check("mid_wr_count", n_wr - w0, 1);
    check("mid_wr_addr", int'(o_wa), 'h01);
    check("mid_wr_data", int'(o_wd), 'h02);
    check("mid_err_cnt", int'(err_cnt), 0);

    // Random frames
    txq.delete(); exp_wr = 0; exp_chk = 0;
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 3);
      a    = 8'($urandom);
      d    = 8'($urandom);
      if (kind == 3) begin
        nj = $urandom_range(1, 3);
        for (int k = 0; k < nj; k++) begin
          j = 8'($urandom);
          if (j == 8'hA5) j = 8'h5A;
          txq.push_back(j);
        end
      end
      txq.push_back(8'hA5); txq.push_back(a); txq.push_back(d);
      if (kind == 2) begin
        txq.push_back(8'(a + d + 8'($urandom_range(1, 255))));
        exp_chk++;
      end else begin
        txq.push_back(8'(a + d));
        exp_wr++;
      end
    end
    w0 = n_wr; c0 = n_chk;
    send(3); idle(3);
    check("rand_wr_count", n_wr - w0, exp_wr);
    check("rand_chk_count", n_chk - c0, exp_chk);

    // Error counter saturation
    do_reset();
    txq.delete();
    for (int f = 0; f < 260; f++) begin
      txq.push_back(8'hA5); txq.push_back(8'h01); txq.push_back(8'h01); txq.push_back(8'h00);
    end
    c0 = n_chk;
    send(0); idle(3);
    check("sat_chk_count", n_chk - c0, 260);
    check("sat_err_cnt", int'(err_cnt), 255);

`ifdef UART_CMD_TIMEOUT_EN
    do_reset();
    t0 = n_to;
    txq = '{8'hA5};
    send(0);
    a5_edge = acc_edge;
    idle(TO + 5);
    check("to_pulses", n_to - t0, 1);
    check("to_gap_cycle", to_edge - a5_edge, TO);
    check("to_busy", int'(busy), 0);
    check("to_err_cnt", int'(err_cnt), 1);
    w0 = n_wr;
    txq = '{8'hA5, 8'h0C, 8'h0D, 8'h19};
    send(1); idle(3);
    check("to_next_wr", n_wr - w0, 1);
    check("to_next_addr", int'(o_wa), 'h0C);
    check("to_next_data", int'(o_wd), 'h0D);
`else
    t0 = n_to;
    idle(5);
    check("no_timeout", n_to - t0, 0);
    a5_edge = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
